csr_axil_initiator: RTL and testbench

AXI-lite initiator (MMIO master) that converts a simple command stream (read/write, 64-bit CSR) into single AXI-lite transactions and returns one response per command. It is the requesting end of the MMIO CSR protocol, used to program and poll DMA CSRs from on-chip sequencers and as the bench-side driver. It keeps one transaction outstanding at a time, enforces a response timeout, and discards stale responses.

---
 rtl/csr_axil_initiator_pkg.sv | 32 +++
 rtl/csr_axil_initiator_if.sv | 48 ++++
 rtl/csr_init_timeout_cntr.sv | 28 ++
 rtl/csr_axil_initiator.sv | 192 +++++++++++++++++++
 tb/tb_csr_axil_initiator.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_axil_initiator_pkg.sv
// Shared types and constants for the CSR AXI-lite initiator.
package csr_axil_initiator_pkg;

   // Top-level sequencing states of the initiator.
   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp,
      StRsp
   } t_csr_init_state;

   // Response error codes returned on rsp_err.
   localparam logic [1:0] RSP_OK         = 2'b00;
   localparam logic [1:0] RSP_SLVERR     = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT    = 2'b10;
   localparam logic [1:0] RSP_IDMISMATCH = 2'b11;

   // AXI bresp/rresp encodings.
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Saturating add for the 8-bit stale-response counter.
   function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/csr_axil_initiator_if.sv
// AXI-lite bus between the CSR initiator (master) and a CSR target (slave).
interface csr_axil_initiator_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 4
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic [ID_W-1:0]       awid;

   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;

   logic                  bvalid;
   logic                  bready;
   logic [ID_W-1:0]       bid;
   logic [1:0]            bresp;

   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     araddr;
   logic [ID_W-1:0]       arid;

   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic [ID_W-1:0]       rid;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awid, input awready,
      output wvalid, wdata, wstrb, input wready,
      input bvalid, bid, bresp, output bready,
      output arvalid, araddr, arid, input arready,
      input rvalid, rdata, rid, rresp, output rready
   );

   modport slave (
      input awvalid, awaddr, awid, output awready,
      input wvalid, wdata, wstrb, output wready,
      output bvalid, bid, bresp, input bready,
      input arvalid, araddr, arid, output arready,
      output rvalid, rdata, rid, rresp, input rready
   );
endinterface

// File: rtl/csr_init_timeout_cntr.sv
// Response-wait counter: cleared before a response phase, counts waiting cycles,
// flags the last permitted waiting cycle.
module csr_init_timeout_cntr #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;

   // expired marks the TIMEOUT_CYCLES-th waiting cycle; the FSM leaves on its edge.
   assign expired = enable && (count_q == LAST);

   // Count waiting cycles; hold once the limit is hit.
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/csr_axil_initiator.sv
// CSR command stream to single outstanding AXI-lite transactions, with response
// timeout and draining of stale responses.
module csr_axil_initiator
   import csr_axil_initiator_pkg::*;
#(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned ID_W           = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_err,
   output logic [7:0]        stale_cnt,
   csr_axil_initiator_if.master axi
);
   t_csr_init_state   state_q;
   logic              cmd_ready_q;
   logic              awvalid_q;
   logic              wvalid_q;
   logic              arvalid_q;
   logic              resp_ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [1:0]        rsp_err_q;
   logic [7:0]        stale_cnt_q;
   logic [ID_W-1:0]   next_id_q;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   logic              b_hs;
   logic              r_hs;
   logic              b_stale;
   logic              r_stale;
   logic              aw_done;
   logic              w_done;
   logic              tmo_clear;
   logic              tmo_enable;
   logic              tmo_expired;
   logic [2:0]        unused_addr_lsb;

   // Bus addresses are 8-byte aligned; the low bits are dropped.
   assign unused_addr_lsb = cmd_addr[2:0];

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign stale_cnt   = stale_cnt_q;

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = addr_q;
   assign axi.awid    = id_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.wdata   = data_q;
   assign axi.wstrb   = '1;
   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = addr_q;
   assign axi.arid    = id_q;
   // Ready is held high everywhere outside reset so late responses are always drained.
   assign axi.bready  = resp_ready_q;
   assign axi.rready  = resp_ready_q;

   assign b_hs    = axi.bvalid && resp_ready_q;
   assign r_hs    = axi.rvalid && resp_ready_q;
   // Only the channel owned by the current response state is consumed as a response.
   assign b_stale = b_hs && (state_q != StWrResp);
   assign r_stale = r_hs && (state_q != StRdResp);

   assign aw_done = !awvalid_q || axi.awready;
   assign w_done  = !wvalid_q || axi.wready;

   // Request states always precede a response state, so clearing here zeroes it on entry.
   assign tmo_clear  = (state_q == StWrReq) || (state_q == StRdReq);
   assign tmo_enable = (state_q == StWrResp) || (state_q == StRdResp);

   csr_init_timeout_cntr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // Main FSM with registered handshake and response outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cmd_ready_q  <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         resp_ready_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= RSP_OK;
         stale_cnt_q  <= '0;
         next_id_q    <= '0;
         id_q         <= '0;
         addr_q       <= '0;
         data_q       <= '0;
      end else begin
         resp_ready_q <= 1'b1;
         stale_cnt_q  <= sat_add8(stale_cnt_q, {1'b0, b_stale} + {1'b0, r_stale});
         unique case (state_q)
            StIdle: begin
               cmd_ready_q <= 1'b1;
               if (cmd_ready_q && cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= {cmd_addr[ADDR_W-1:3], 3'b000};
                  data_q      <= cmd_data;
                  id_q        <= next_id_q;
                  next_id_q   <= next_id_q + ID_W'(1);
                  if (cmd_write) begin
                     state_q   <= StWrReq;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= StRdReq;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            StWrReq: begin
               if (axi.awready) awvalid_q <= 1'b0;
               if (axi.wready) wvalid_q <= 1'b0;
               if (aw_done && w_done) state_q <= StWrResp;
            end
            StRdReq: begin
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  state_q   <= StRdResp;
               end
            end
            StWrResp: begin
               if (b_hs) begin
                  state_q     <= StRsp;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  if (axi.bid != id_q) rsp_err_q <= RSP_IDMISMATCH;
                  else if (axi.bresp != OKAY) rsp_err_q <= RSP_SLVERR;
                  else rsp_err_q <= RSP_OK;
               end else if (tmo_expired) begin
                  state_q     <= StRsp;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= RSP_TIMEOUT;
               end
            end
            StRdResp: begin
               if (r_hs) begin
                  state_q     <= StRsp;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  if (axi.rid != id_q) begin
                     rsp_err_q <= RSP_IDMISMATCH;
                  end else if (axi.rresp != OKAY) begin
                     rsp_err_q <= RSP_SLVERR;
                  end else begin
                     rsp_err_q  <= RSP_OK;
                     rsp_data_q <= axi.rdata;
                  end
               end else if (tmo_expired) begin
                  state_q     <= StRsp;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= RSP_TIMEOUT;
               end
            end
            StRsp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_csr_axil_initiator.sv
// Directed bench for csr_axil_initiator with hand-computed expectations.
module tb_csr_axil_initiator;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [63:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_err;
   logic [7:0]  stale_cnt;

   int          errors = 0;
   int          checks = 0;
   logic [3:0]  exp_id = 4'd0;
   logic [3:0]  tmo_id;
   int          n;

   csr_axil_initiator_if #(.ADDR_W(16), .DATA_W(64), .ID_W(4)) axi ();

   csr_axil_initiator #(
      .ADDR_W         (16),
      .DATA_W         (64),
      .ID_W           (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .stale_cnt (stale_cnt),
      .axi       (axi)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input string tag, input bit wr, input logic [15:0] addr,
                        input logic [63:0] wdat);
      int k;
      k = 0;
      while (!cmd_ready && k < 20) begin
         tick();
         k++;
      end
      chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_data  = wdat;
      tick();
      cmd_valid = 1'b0;
   endtask

   // One command against a zero-wait responder; readies must already be high.
   task automatic do_txn(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [63:0] wdat, input logic [3:0] id_xor,
                         input logic [1:0] resp, input logic [63:0] rdat, input bit extra_b,
                         input logic [1:0] exp_err, input logic [63:0] exp_data);
      issue(tag, wr, addr, wdat);
      if (wr) begin
         chk({tag, "_valids"}, {61'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 64'd6);
         chk({tag, "_awaddr"}, {48'd0, axi.awaddr}, {48'd0, addr & 16'hFFF8});
         chk({tag, "_awid"}, {60'd0, axi.awid}, {60'd0, exp_id});
         chk({tag, "_wdata"}, axi.wdata, wdat);
         chk({tag, "_wstrb"}, {56'd0, axi.wstrb}, 64'hFF);
      end else begin
         chk({tag, "_valids"}, {61'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 64'd1);
         chk({tag, "_araddr"}, {48'd0, axi.araddr}, {48'd0, addr & 16'hFFF8});
         chk({tag, "_arid"}, {60'd0, axi.arid}, {60'd0, exp_id});
      end
      tick();
      chk({tag, "_req_done"},
          {60'd0, axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid}, 64'd0);
      if (wr) begin
         axi.bvalid = 1'b1;
         axi.bid    = exp_id ^ id_xor;
         axi.bresp  = resp;
      end else begin
         axi.rvalid = 1'b1;
         axi.rid    = exp_id ^ id_xor;
         axi.rresp  = resp;
         axi.rdata  = rdat;
         if (extra_b) begin
            axi.bvalid = 1'b1;
            axi.bid    = exp_id + 4'd7;
            axi.bresp  = 2'b00;
         end
      end
      tick();
      axi.bvalid = 1'b0;
      axi.rvalid = 1'b0;
      chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, "_rsp_err"}, {62'd0, rsp_err}, {62'd0, exp_err});
      chk({tag, "_rsp_data"}, rsp_data, exp_data);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_back_idle"}, {62'd0, rsp_valid, cmd_ready}, 64'd1);
      exp_id = exp_id + 4'd1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within 50000 time units");
      $fatal(1);
   end

   initial begin
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_data    = '0;
      rsp_ready   = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.arready = 1'b0;
      axi.bvalid  = 1'b0;
      axi.bid     = '0;
      axi.bresp   = '0;
      axi.rvalid  = 1'b0;
      axi.rid     = '0;
      axi.rresp   = '0;
      axi.rdata   = '0;
      tick();
      tick();
      tick();

      // Reset state.
      chk("rst_ctrl", {57'd0, cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
                       axi.rready, rsp_valid}, 64'd0);
      chk("rst_rsp", {54'd0, rsp_err, stale_cnt}, 64'd0);
      chk("rst_data", rsp_data, 64'd0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_ready", {61'd0, cmd_ready, axi.bready, axi.rready}, 64'd7);

      // Write 0x28, zero-wait responder; response visible third cycle after accept.
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
      axi.arready = 1'b1;
      do_txn("wr28", 1'b1, 16'h0028, 64'h0000_0001_0000_1000, 4'd0, 2'b00, 64'd0, 1'b0,
             2'b00, 64'd0);

      // AW ready delayed 5 cycles, W ready immediate.
      axi.awready = 1'b0;
      issue("awdly", 1'b1, 16'h0030, 64'hA5A5_5A5A_0F0F_F0F0);
      chk("awdly_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
      tick();
      chk("awdly_w_drop", {63'd0, axi.wvalid}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("awdly_hold", {47'd0, axi.awvalid, axi.awaddr}, {47'd0, 1'b1, 16'h0030});
         if (i == 3) axi.awready = 1'b1;
         tick();
      end
      chk("awdly_aw_drop", {62'd0, axi.awvalid, rsp_valid}, 64'd0);
      axi.bvalid = 1'b1;
      axi.bid    = exp_id;
      axi.bresp  = 2'b00;
      tick();
      axi.bvalid = 1'b0;
      chk("awdly_rsp", {61'd0, rsp_valid, rsp_err}, 64'h4);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("awdly_single_b", {55'd0, rsp_valid, stale_cnt}, 64'd0);
      exp_id = exp_id + 4'd1;

      // Reads: OKAY with data, then SLVERR on an unaligned address.
      do_txn("rd00", 1'b0, 16'h0000, 64'd0, 4'd0, 2'b00, 64'h1000_0100_0000_0000, 1'b0,
             2'b00, 64'h1000_0100_0000_0000);
      do_txn("rdslv", 1'b0, 16'h000F, 64'd0, 4'd0, 2'b10, 64'hDEAD_BEEF_0000_0001, 1'b0,
             2'b01, 64'd0);
      // Write answered with the wrong bid.
      do_txn("wrid", 1'b1, 16'h0040, 64'h1234, 4'd1, 2'b00, 64'd0, 1'b0, 2'b11, 64'd0);

      // Fill the id space so the next command wraps to id 0.
      for (int i = 0; i < 11; i++) begin
         do_txn("fill", 1'b1, 16'h0100 + 16'(i * 8), 64'(i), 4'd0, 2'b00, 64'd0, 1'b0,
                2'b00, 64'd0);
      end
      chk("id_wrapped_model", {60'd0, exp_id}, 64'd0);
      do_txn("wrap", 1'b0, 16'h0018, 64'd0, 4'd0, 2'b00, 64'h0000_0000_CAFE_F00D, 1'b0,
             2'b00, 64'h0000_0000_CAFE_F00D);

      // Write never answered: timeout 16 cycles after entering the response phase.
      tmo_id = exp_id;
      issue("tmo", 1'b1, 16'h0048, 64'h55);
      chk("tmo_awid", {60'd0, axi.awid}, {60'd0, tmo_id});
      tick();
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      chk("tmo_cycles", 64'(n), 64'd16);
      chk("tmo_err", {62'd0, rsp_err}, 64'd2);
      chk("tmo_data", rsp_data, 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_id = exp_id + 4'd1;
      // Late B arrives while idle.
      axi.bvalid = 1'b1;
      axi.bid    = tmo_id;
      axi.bresp  = 2'b00;
      tick();
      axi.bvalid = 1'b0;
      tick();
      tick();
      chk("late_b_stale", {55'd0, rsp_valid, stale_cnt}, 64'd1);

      // B and R together during a read response: R taken, B counted stale.
      do_txn("both", 1'b0, 16'h0020, 64'd0, 4'd0, 2'b00, 64'h0BAD_F00D_1111_2222, 1'b1,
             2'b00, 64'h0BAD_F00D_1111_2222);
      chk("both_stale", {56'd0, stale_cnt}, 64'd2);

      // Reset while waiting for R abandons the read.
      issue("rstrd", 1'b0, 16'h0050, 64'd0);
      tick();
      chk("rstrd_in_resp", {62'd0, axi.arvalid, rsp_valid}, 64'd0);
      reset_n = 1'b0;
      tick();
      chk("rstrd_ctrl", {57'd0, cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
                         axi.rready, rsp_valid}, 64'd0);
      chk("rstrd_rsp", {54'd0, rsp_err, stale_cnt}, 64'd0);
      reset_n = 1'b1;
      exp_id  = 4'd0;
      tick();
      tick();
      chk("rstrd_no_rsp", {63'd0, rsp_valid}, 64'd0);
      do_txn("after_rst", 1'b0, 16'h0058, 64'd0, 4'd0, 2'b00, 64'h77, 1'b0, 2'b00, 64'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
